display_scan_controller: RTL and testbench
==========================================

# display_scan_controller

Time-multiplexed scan controller that shares one 7-segment decoder among `NUM_DIGITS` common-anode digits. It holds a displayed value and selects one digit at a time. For each slot it presents that digit's 4-bit nibble to the shared decoder and drives the matching active-low digit enable, with a dead-time guard between slots to prevent ghosting. New values enter through a req/ack handshake and are applied only at frame boundaries, so a frame never shows mixed old and new digits.

## Interface
- `NUM_DIGITS`, 4, number of digits scanned; legal range 1..8.
- `REFRESH_DIV`, 50000, clock cycles per digit slot; must be ≥ 2.
- `GUARD_CYCLES`, 500, all-off cycles at the start of each slot; must satisfy 0 ≤ `GUARD_CYCLES` < `REFRESH_DIV`.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `value_in`  in  4*NUM_DIGITS  value to display; nibble k (`value_in[4k+3:4k]`) goes to digit k, and digit 0 is least significant.
- `load_req`  in  1  requester holds this high, with `value_in` stable, until `load_ack`.
- `load_ack`  out  1  one-cycle pulse confirming capture of `value_in`.
- `blank_en`  in  1  level; forces all digits off while high.
- `digit_nibble`  out  4  nibble to the shared 7-segment decoder.
- `digit_sel`  out  NUM_DIGITS  active-low digit enables; at most one bit is low.
- `digit_blank`  out  1  high whenever all `digit_sel` bits are high.
- `frame_done`  out  1  one-cycle pulse at each frame boundary.

## Operation
- Internal state:
  - display register `disp` (4*NUM_DIGITS bits)
  - slot counter `cnt` (0..REFRESH_DIV-1)
  - digit index `idx` (0..NUM_DIGITS-1)
  - FSM with states GUARD and DRIVE.
- `cnt` increments every cycle. When it wraps from REFRESH_DIV-1 to 0, `idx` advances; from NUM_DIGITS-1 it wraps to 0.
- FSM transitions:
  - The FSM is in GUARD while `cnt` < GUARD_CYCLES and in DRIVE otherwise.
  - GUARD→DRIVE occurs on the edge where `cnt` becomes GUARD_CYCLES.
  - DRIVE→GUARD occurs on the slot wrap. If GUARD_CYCLES = 0, the FSM goes DRIVE→DRIVE with the new `idx`.
- In GUARD, `digit_sel` is all ones and `digit_blank` = 1.
- In DRIVE, `digit_sel[idx]` = 0 and `digit_nibble` = `disp[4*idx+3:4*idx]`, unless the digit is blanked (`blank_en`, or see Configuration).
- A blanked digit keeps `digit_sel` all ones and `digit_blank` = 1, while `digit_nibble` still shows the digit's nibble.
- Frame boundary is the edge where `cnt` and `idx` both wrap. On that edge:
  - `frame_done` pulses.
  - If `load_req` = 1, `disp` ← `value_in` and `load_ack` pulses for exactly one cycle.
  - The new value is displayed starting with slot 0 of the next frame.
- If `load_req` drops before a boundary, nothing is captured and no ack is sent.
- After an ack, `load_req` must be low for at least one cycle before the next request. If `load_req` is still high at the following boundary, that counts as a new capture.
- `blank_en` takes effect on the next edge; scanning and handshakes keep running while it is high.
- Reset values: `disp`=0, `cnt`=0, `idx`=0, state GUARD, `digit_sel` all ones, `digit_nibble`=0, `digit_blank`=1, `load_ack`=0, `frame_done`=0.
- If `rst` is asserted mid-frame, all state returns to reset values on the next edge and any pending request is dropped. `rst` wins over a simultaneous boundary capture.

## Timing
- All outputs are registered and change only on `clk` rising edges.
- Slot length: REFRESH_DIV cycles, of which DRIVE lasts exactly REFRESH_DIV-GUARD_CYCLES cycles.
- Frame length: NUM_DIGITS*REFRESH_DIV cycles. The first boundary is the (NUM_DIGITS*REFRESH_DIV)th rising edge after `rst` deasserts.
- Load latency: from 1 cycle up to one frame, from `load_req` rising to `load_ack`. `load_ack` and `frame_done` are high in the same cycle.
- No combinational path from any input to any output.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - In DRIVE, digit k > 0 is blanked when `disp` nibbles k..NUM_DIGITS-1 are all zero.
  - Digit 0 is always shown.
  - The blank mask is computed from `disp`, so it changes only at frame boundaries.
- Undefined: every digit is shown, including leading zeros.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2.
- Reset: assert `rst` for 2 cycles mid-scan → `digit_sel`=4'b1111, `digit_blank`=1, `digit_nibble`=0, `load_ack`=0, `frame_done`=0 on the next edge.
- Load: hold `load_req`=1 with `value_in`=16'h1234 from reset → `load_ack`/`frame_done` high on the 32nd edge. In the next frame, DRIVE shows sel 1110/nibble 4, 1101/3, 1011/2, 0111/1.
- Guard timing: each slot has 2 cycles with `digit_sel`=1111, then 6 cycles with one bit low. The pattern repeats every 8 cycles, and no two bits are ever low together.
- Aborted request: raise `load_req` at cycle 5 and drop it at cycle 20 with value 16'hABCD → no `load_ack`, and `disp` stays 0.
- Blank: set `blank_en`=1 for one frame → `digit_sel`=1111 throughout while `frame_done` still pulses every 32 cycles. Clearing it restores the scan on the next edge.
- Leading zeros (macro defined):
  - Load 16'h0050 → digits 2 and 3 stay off, digit 1 shows 5, digit 0 shows 0.
  - Load 16'h0000 → only digit 0 lights.
  - With the macro undefined, all four digits light.

Source files
------------

// File: rtl/display_scan_if.sv
// Load handshake and scan outputs of display_scan_controller, grouped as one bus.
// The requester uses modport master and the controller uses modport slave.
interface display_scan_if #(
    parameter int NUM_DIGITS = 4
);
    // Handshake: the requester raises load_req with value_in stable and holds both
    // until load_ack. load_ack is a one-cycle pulse issued only at a frame boundary.
    // Dropping load_req before that boundary withdraws the request without an ack.
    // After an ack, load_req stays low for at least one cycle before the next request.
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    load_req;
    logic                    load_ack;
    logic                    blank_en;
    logic [3:0]              digit_nibble;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic                    digit_blank;
    logic                    frame_done;
    logic                    scan_state;  // debug view of the FSM: 1 = DRIVE, 0 = GUARD

    modport master (
        output value_in, load_req, blank_en,
        input  load_ack, digit_nibble, digit_sel, digit_blank, frame_done, scan_state
    );

    modport slave (
        input  value_in, load_req, blank_en,
        output load_ack, digit_nibble, digit_sel, digit_blank, frame_done, scan_state
    );
endinterface

// File: rtl/display_scan_controller.sv
// Time-multiplexed common-anode digit scanner with guard time and frame-aligned loads.
// Optional macro LEADING_ZERO_BLANK_EN: suppress leading zero digits (digit 0 always shown).
module display_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic           clk,
    input  logic           rst,
    display_scan_if.slave  bus
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t                  state, state_nx;
    logic [CW-1:0]           cnt, cnt_nx;
    logic [IW-1:0]           idx, idx_nx;
    logic [4*NUM_DIGITS-1:0] disp, disp_nx;
    logic                    slot_wrap, frame_wrap, capture;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   sel_nx;
    logic                    digit_off;

    // Outputs are registered from next-state values so they line up with cnt/idx/state.
    always_comb begin
        slot_wrap  = (cnt == CNT_LAST);
        frame_wrap = slot_wrap && (idx == IDX_LAST);
        capture    = frame_wrap && bus.load_req;
        cnt_nx     = slot_wrap ? '0 : cnt + 1'b1;
        idx_nx     = idx;
        if (slot_wrap) begin
            idx_nx = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
        disp_nx  = capture ? bus.value_in : disp;
        state_nx = (cnt_nx >= GUARD_END) ? DRIVE : GUARD;
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic lz_run;

    // Digit k is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        lz_mask = '0;
        lz_run  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            lz_run     = lz_run & (disp_nx[4*k +: 4] == 4'h0);
            lz_mask[k] = lz_run;
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        sel_nx    = '1;
        digit_off = bus.blank_en | lz_mask[idx_nx];
        if ((state_nx == DRIVE) && !digit_off) begin
            sel_nx[idx_nx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt              <= '0;
            idx              <= '0;
            disp             <= '0;
            state            <= GUARD;
            bus.digit_sel    <= '1;
            bus.digit_nibble <= 4'h0;
            bus.digit_blank  <= 1'b1;
            bus.load_ack     <= 1'b0;
            bus.frame_done   <= 1'b0;
        end else begin
            cnt              <= cnt_nx;
            idx              <= idx_nx;
            disp             <= disp_nx;
            state            <= state_nx;
            bus.digit_sel    <= sel_nx;
            bus.digit_nibble <= disp_nx[int'(idx_nx)*4 +: 4];
            bus.digit_blank  <= &sel_nx;
            bus.load_ack     <= capture;
            bus.frame_done   <= frame_wrap;
        end
    end

    assign bus.scan_state = (state == DRIVE);
endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller (4 digits, 8-cycle slots, 2 guard cycles) against a
// cycle-count based reference model.
module tb_display_scan_controller;
    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int GC    = 2;
    localparam int FRAME = ND * RD;

    logic clk = 1'b0;
    logic rst = 1'b1;

    display_scan_if #(.NUM_DIGITS(ND)) bus ();

    display_scan_controller #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .GUARD_CYCLES(GC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: n = edges since reset released; slot/digit follow from n.
    int          n = 0;
    logic [15:0] m_disp = '0;
    logic [3:0]  e_sel;
    logic [3:0]  e_nib;
    logic        e_blank, e_fd, e_ack, e_drive;
    logic [7:0]  exp_q[$];

    task automatic tick();
        logic        r, q, b, lzb, bnd;
        logic [15:0] v;
        int          cnt, idx;
        r = rst;
        q = bus.load_req;
        b = bus.blank_en;
        v = bus.value_in;
        @(posedge clk);
        #1;
        if (r) begin
            n      = 0;
            m_disp = '0;
        end else begin
            n++;
        end
        cnt   = n % RD;
        idx   = (n / RD) % ND;
        bnd   = !r && (n > 0) && ((n % FRAME) == 0);
        e_fd  = bnd;
        e_ack = bnd && q;
        if (e_ack) m_disp = v;
        e_drive = (cnt >= GC);
        lzb = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        lzb = (idx > 0) && ((m_disp >> (4 * idx)) == 16'h0);
`endif
        e_sel   = (e_drive && !b && !lzb) ? ~(4'b0001 << idx) : 4'hF;
        e_blank = (e_sel == 4'hF);
        e_nib   = m_disp[4*idx +: 4];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.digit_sel !== 4'hF || bus.digit_blank !== 1'b1 || bus.digit_nibble !== 4'h0 ||
                bus.load_ack !== 1'b0 || bus.frame_done !== 1'b0) begin
                failures++;
                $display("FAIL reset_pwrup sel=%b blank=%b nib=%h ack=%b fd=%b required 1111/1/0/0/0",
                         bus.digit_sel, bus.digit_blank, bus.digit_nibble, bus.load_ack, bus.frame_done);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_load();
        int         ack_n;
        logic [3:0] prev;
        logic [7:0] got, want;
        ack_n = -1;
        bus.value_in = 16'h1234;
        bus.load_req = 1'b1;
        for (int i = 0; i < FRAME + 4 && ack_n < 0; i++) begin
            tick();
            checks++;
            if (bus.digit_sel !== e_sel || bus.digit_blank !== e_blank || bus.frame_done !== e_fd ||
                bus.load_ack !== e_ack || (e_drive && bus.digit_nibble !== e_nib)) begin
                failures++;
                $display("FAIL load_scan n=%0d sel=%b exp=%b fd=%b exp=%b ack=%b exp=%b nib=%h exp=%h",
                         n, bus.digit_sel, e_sel, bus.frame_done, e_fd, bus.load_ack, e_ack,
                         bus.digit_nibble, e_nib);
            end
            if (bus.load_ack === 1'b1) ack_n = n;
        end
        bus.load_req = 1'b0;
        checks++;
        if (ack_n != FRAME) begin
            failures++;
            $display("FAIL load_latency ack_edge=%0d required=%0d", ack_n, FRAME);
        end
        checks++;
        if (bus.frame_done !== 1'b1) begin
            failures++;
            $display("FAIL load_ack_with_frame_done fd=%b required=1", bus.frame_done);
        end
        exp_q.push_back({4'b1110, 4'h4});
        exp_q.push_back({4'b1101, 4'h3});
        exp_q.push_back({4'b1011, 4'h2});
        exp_q.push_back({4'b0111, 4'h1});
        prev = 4'hF;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (bus.digit_sel !== 4'hF && bus.digit_sel !== prev) begin
                got = {bus.digit_sel, bus.digit_nibble};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL load_digit_extra got=%h required=none", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        failures++;
                        $display("FAIL load_digit sel/nib=%b/%h required=%b/%h",
                                 got[7:4], got[3:0], want[7:4], want[3:0]);
                    end
                end
            end
            prev = bus.digit_sel;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL load_digit_missing left=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 13; i++) tick();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.digit_sel !== 4'hF || bus.digit_blank !== 1'b1 || bus.digit_nibble !== 4'h0 ||
                bus.load_ack !== 1'b0 || bus.frame_done !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid sel=%b blank=%b nib=%h ack=%b fd=%b required 1111/1/0/0/0",
                         bus.digit_sel, bus.digit_blank, bus.digit_nibble, bus.load_ack, bus.frame_done);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_guard_timing();
        int run_off;
        run_off = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            checks++;
            if (bus.digit_sel !== e_sel || bus.digit_blank !== e_blank || bus.frame_done !== e_fd ||
                bus.load_ack !== e_ack || (e_drive && bus.digit_nibble !== e_nib)) begin
                failures++;
                $display("FAIL guard_scan n=%0d sel=%b exp=%b blank=%b exp=%b fd=%b exp=%b nib=%h exp=%h",
                         n, bus.digit_sel, e_sel, bus.digit_blank, e_blank, bus.frame_done, e_fd,
                         bus.digit_nibble, e_nib);
            end
            checks++;
            if ($countones(~bus.digit_sel) > 1) begin
                failures++;
                $display("FAIL guard_onehot sel=%b required at most one low bit", bus.digit_sel);
            end
            run_off = (bus.digit_sel === 4'hF) ? run_off + 1 : 0;
            if (run_off > GC) begin
                checks++;
                failures++;
                $display("FAIL guard_length off_run=%0d required<=%0d", run_off, GC);
            end
        end
    endtask

    task automatic test_abort();
        int acks;
        acks = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.value_in = 16'hABCD;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (n == 5)  bus.load_req = 1'b1;
            if (n == 20) bus.load_req = 1'b0;
            tick();
            if (bus.load_ack === 1'b1) acks++;
            if (n > FRAME && e_drive) begin
                checks++;
                if (bus.digit_nibble !== 4'h0) begin
                    failures++;
                    $display("FAIL abort_disp n=%0d nib=%h required=0", n, bus.digit_nibble);
                end
            end
        end
        checks++;
        if (acks != 0) begin
            failures++;
            $display("FAIL abort_ack acks=%0d required=0", acks);
        end
    endtask

    task automatic test_blank();
        int fds;
        fds = 0;
        bus.blank_en = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (bus.frame_done === 1'b1) fds++;
            checks++;
            if (bus.digit_sel !== 4'hF || bus.digit_blank !== 1'b1) begin
                failures++;
                $display("FAIL blank_sel n=%0d sel=%b blank=%b required 1111/1",
                         n, bus.digit_sel, bus.digit_blank);
            end
        end
        checks++;
        if (fds != 1) begin
            failures++;
            $display("FAIL blank_frame_done pulses=%0d required=1", fds);
        end
        bus.blank_en = 1'b0;
        for (int i = 0; i < RD; i++) begin
            tick();
            checks++;
            if (bus.digit_sel !== e_sel || bus.digit_blank !== e_blank || bus.frame_done !== e_fd) begin
                failures++;
                $display("FAIL blank_restore n=%0d sel=%b exp=%b blank=%b exp=%b fd=%b exp=%b",
                         n, bus.digit_sel, e_sel, bus.digit_blank, e_blank, bus.frame_done, e_fd);
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [15:0] vals[2];
        logic [3:0]  want_lit[2];
        logic [3:0]  lit;
        vals[0] = 16'h0050;
        vals[1] = 16'h0000;
`ifdef LEADING_ZERO_BLANK_EN
        want_lit[0] = 4'b0011;
        want_lit[1] = 4'b0001;
`else
        want_lit[0] = 4'b1111;
        want_lit[1] = 4'b1111;
`endif
        for (int t = 0; t < 2; t++) begin
            bus.value_in = vals[t];
            bus.load_req = 1'b1;
            for (int i = 0; i < FRAME + 2 && bus.load_ack !== 1'b1; i++) tick();
            bus.load_req = 1'b0;
            checks++;
            if (bus.load_ack !== 1'b1) begin
                failures++;
                $display("FAIL lz_ack value=%h ack=%b required=1", vals[t], bus.load_ack);
            end
            lit = 4'h0;
            for (int i = 0; i < FRAME; i++) begin
                tick();
                lit = lit | ~bus.digit_sel;
                checks++;
                if (bus.digit_sel !== e_sel || (e_drive && bus.digit_nibble !== e_nib)) begin
                    failures++;
                    $display("FAIL lz_scan n=%0d sel=%b exp=%b nib=%h exp=%h",
                             n, bus.digit_sel, e_sel, bus.digit_nibble, e_nib);
                end
            end
            checks++;
            if (lit !== want_lit[t]) begin
                failures++;
                $display("FAIL lz_lit value=%h lit=%b required=%b", vals[t], lit, want_lit[t]);
            end
        end
    endtask

    task automatic test_reset_boundary();
        bus.value_in = 16'h5A5A;
        bus.load_req = 1'b1;
        for (int i = 0; i < FRAME && ((n + 1) % FRAME) != 0; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.load_req = 1'b0;
        checks++;
        if (bus.load_ack !== 1'b0 || bus.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_boundary ack=%b fd=%b required 0/0", bus.load_ack, bus.frame_done);
        end
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (e_drive) begin
                checks++;
                if (bus.digit_nibble !== 4'h0) begin
                    failures++;
                    $display("FAIL reset_boundary_disp n=%0d nib=%h required=0", n, bus.digit_nibble);
                end
            end
        end
    endtask

    task automatic test_random();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 900; i++) begin
            tick();
            checks++;
            if (bus.digit_sel !== e_sel || bus.digit_blank !== e_blank || bus.frame_done !== e_fd ||
                bus.load_ack !== e_ack || (e_drive && bus.digit_nibble !== e_nib)) begin
                failures++;
                $display("FAIL rand_scan n=%0d sel=%b exp=%b blank=%b exp=%b fd=%b exp=%b ack=%b exp=%b nib=%h exp=%h",
                         n, bus.digit_sel, e_sel, bus.digit_blank, e_blank, bus.frame_done, e_fd,
                         bus.load_ack, e_ack, bus.digit_nibble, e_nib);
            end
            if (bus.load_ack === 1'b1) begin
                bus.load_req = 1'b0;
            end else if (bus.load_req && $urandom_range(0, 79) == 0) begin
                bus.load_req = 1'b0;
            end else if (!bus.load_req && $urandom_range(0, 9) == 0) begin
                bus.value_in = 16'($urandom);
                bus.load_req = 1'b1;
            end
            if ($urandom_range(0, 39) == 0) bus.blank_en = ~bus.blank_en;
        end
        bus.load_req = 1'b0;
        bus.blank_en = 1'b0;
    endtask

    initial begin
        bus.value_in = '0;
        bus.load_req = 1'b0;
        bus.blank_en = 1'b0;
        test_reset();
        test_load();
        test_reset_mid();
        test_guard_timing();
        test_abort();
        test_blank();
        test_leading_zero();
        test_reset_boundary();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
